clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised successor to the single free-running clock divider.
- Keeps a free-running CNT_W-bit divide counter, clkdiv.
- Adds NCH independent channels. Each channel has a runtime-programmable divide ratio with shadowed reload, a per-channel enable, a 50%-square or single-pulse output mode, and a global synchronous restart.
- Sits directly after the board clock buffer. Its outputs feed LED/scan/debounce logic as clock enables; they are never used as clocks.

Parameters:
- CNT_W, 32, width of free-running clkdiv counter.
- NCH, 4, number of divider channels (1..16).
- DIV_W, 16, width of each channel divide ratio.
- DEF_RATIO, 16'd99, reset value of every channel's active and shadow ratio.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- div_ratio  in  NCH*DIV_W  per-channel ratio R; channel i uses bits [i*DIV_W +: DIV_W]; period = R+1 cycles.
- div_load  in  NCH  one-cycle strobe; captures div_ratio slice i into shadow i.
- ch_en  in  NCH  channel enable, level.
- mode  in  NCH  0 = sq is toggle square (period 2(R+1)); 1 = sq is single-cycle pulse (equals tick).
- sync_restart  in  1  one-cycle strobe; realigns all channels.
- clkdiv  out  CNT_W  free-running counter.
- tick  out  NCH  one-cycle clock-enable pulse per channel period.
- sq  out  NCH  mode-dependent channel output, registered.

Behaviour:
- Reset (rst_n low, async):
  - clkdiv=0, all cnt=0, tick=0, sq=0.
  - active and shadow ratio = DEF_RATIO.
  - Reset mid-operation abandons all counts immediately.
- clkdiv:
  - Increments by 1 every cycle, wraps all-ones -> 0.
  - Unaffected by sync_restart, ch_en and div_load.
- Per-channel registers: cnt[DIV_W], act[DIV_W], shd[DIV_W], tick, sq.
- div_load[i]:
  - shd <= slice i at that edge.
  - If the channel is disabled, act also takes the new value at the same edge.
- Enabled channel, each edge:
  - If cnt==act (wrap): cnt<=0, tick<=1, sq toggles (mode 0) or sq<=1 (mode 1), act<=shd.
  - Else: cnt<=cnt+1, tick<=0; sq holds (mode 0) or sq<=0 (mode 1).
- Load coinciding with wrap: the value being loaded goes directly into act at that wrap, bypassing the shadow.
- Load mid-period: takes effect at the next wrap only; the current period completes with the old ratio.
- R=0: tick high every cycle; mode 0 sq toggles every cycle.
- First tick after enable: first asserted on the (R+1)-th rising edge after the first edge at which ch_en[i]=1 is sampled (cnt starts at 0).
- Disable (ch_en[i]=0):
  - At next edge: cnt<=0, tick<=0, sq<=0, act<=shd.
  - Re-enable restarts from cnt=0.
- sync_restart=1 at an edge, all channels, highest priority over wrap and counting:
  - cnt<=0, tick<=0, sq<=0, act<=shd (or the loaded value if div_load is coincident).
  - Enabled channels then tick R+1 edges later, mutually phase-aligned.
- mode change:
  - Takes effect at the next edge.
  - Switching 1->0 leaves sq at 0 unless a wrap occurs on that edge.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package clk_div_pkg:
  - mode constants MODE_SQUARE=1'b0, MODE_PULSE=1'b1.
  - default widths (CNT_W_DEF, DIV_W_DEF).
  - DEF_RATIO default.
- Sub-module clk_div_chan: one channel, containing cnt/act/shd/tick/sq with parameter DIV_W.
  - Instantiated NCH times in a generate loop.
  - Top holds only clkdiv and slice wiring.

Test Plan:
- Reset release, ch_en=0, 70 cycles
  -> clkdiv reads 0..69 in successive cycles; tick=sq=0.
  - Separately, force clkdiv to all-ones (NCH=1, CNT_W=4, 16 cycles) -> wraps to 0.
- Ch0 loaded R=3 while disabled, mode 0, ch_en=1
  -> tick on edges 4,8,12; sq high after edge 4, low after 8 (period 8).
  - Ch1 with R=0, mode 1 -> tick=sq=1 every cycle.
- Ch0 running R=9; div_load R=4 at cnt=5
  -> next wrap still at cnt=9, following periods 5 cycles.
  - Load coincident with wrap -> the very next period is 5.
- Ch0 R=2, ch1 R=5, both enabled, sync_restart at arbitrary cycle
  -> next edge all tick/sq=0, cnt=0; ch0 ticks 3 edges later, ch1 6 edges later; both tick together every 6 cycles.
- ch_en dropped mid-count, raised 3 cycles later
  -> tick/sq=0 while disabled; first tick R+1 edges after re-enable.
- rst_n pulsed low asynchronously mid-period
  -> outputs 0 immediately without a clock edge; act=DEF_RATIO (first tick 100 edges after enable).

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider: default widths,
// default divide ratio and the per-channel output mode encoding.
package clk_div_pkg;

    localparam int          CNT_W_DEF     = 32;
    localparam int          NCH_DEF       = 4;
    localparam int          DIV_W_DEF     = 16;
    localparam logic [15:0] DEF_RATIO_DEF = 16'd99;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the divider: per-channel ratio, load, enable and
// mode in, free-running count and per-channel tick/sq out.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF
);

    logic [NCH*DIV_W-1:0] div_ratio;
    logic [NCH-1:0]       div_load;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       mode;
    logic                 sync_restart;
    logic [CNT_W-1:0]     clkdiv;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       sq;

    modport master (
        output div_ratio, div_load, ch_en, mode, sync_restart,
        input  clkdiv, tick, sq
    );

    modport slave (
        input  div_ratio, div_load, ch_en, mode, sync_restart,
        output clkdiv, tick, sq
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow ratio pair and the
// registered tick / square-or-pulse outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEF_RATIO_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] ratio_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             sq_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             mode_q;
    logic [DIV_W-1:0] reload;
    logic             wrap;
    logic             sq_base;

    always_comb begin
        // A load on the same edge as a reload point bypasses the shadow.
        reload  = load_i ? ratio_i : shd_q;
        shd_d   = reload;
        wrap    = (cnt_q == act_q);
        // Leaving pulse mode starts the square wave from low.
        sq_base = (mode_q == MODE_PULSE) ? 1'b0 : sq_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        tick_d  = 1'b0;
        sq_d    = sq_q;
        if (restart_i || !en_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            act_d = reload;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = (mode_i == MODE_PULSE) ? 1'b1 : ~sq_base;
            act_d  = reload;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            sq_d  = (mode_i == MODE_PULSE) ? 1'b0 : sq_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DEF_RATIO;
            shd_q  <= DEF_RATIO;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
            mode_q <= MODE_SQUARE;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
            mode_q <= mode_i;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/clk_div_multi.sv
// Free-running divide counter plus NCH independent programmable divider
// channels whose outputs serve as clock enables.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               CNT_W     = CNT_W_DEF,
    parameter int               NCH       = NCH_DEF,
    parameter int               DIV_W     = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEF_RATIO_DEF)
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_multi_if.slave bus
);

    logic [CNT_W-1:0] clkdiv_q, clkdiv_d;
    logic [NCH-1:0]   tick_w;
    logic [NCH-1:0]   sq_w;

    assign clkdiv_d = clkdiv_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q <= '0;
        end else begin
            clkdiv_q <= clkdiv_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .DEF_RATIO (DEF_RATIO)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .ratio_i   (bus.div_ratio[i*DIV_W +: DIV_W]),
            .load_i    (bus.div_load[i]),
            .en_i      (bus.ch_en[i]),
            .mode_i    (bus.mode[i]),
            .restart_i (bus.sync_restart),
            .tick_o    (tick_w[i]),
            .sq_o      (sq_w[i])
        );
    end

    assign bus.clkdiv = clkdiv_q;
    assign bus.tick   = tick_w;
    assign bus.sq     = sq_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic, compared
// against an absolute-time tick scheduler model.
module tb_clk_div_multi;

    localparam int CNT_W = 32;
    localparam int NCH   = 4;
    localparam int DIV_W = 16;

    logic clk;
    logic rst_n;
    logic rst_s_n;

    clk_div_multi_if #(.CNT_W(CNT_W), .NCH(NCH), .DIV_W(DIV_W)) bus ();
    clk_div_multi_if #(.CNT_W(4), .NCH(1), .DIV_W(DIV_W)) sbus ();

    clk_div_multi #(
        .CNT_W(CNT_W), .NCH(NCH), .DIV_W(DIV_W), .DEF_RATIO(16'd99)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    clk_div_multi #(
        .CNT_W(4), .NCH(1), .DIV_W(DIV_W), .DEF_RATIO(16'd99)
    ) sdut (
        .clk   (clk),
        .rst_n (rst_s_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned errors;

    // Model: each channel remembers the absolute edge number of its next tick.
    longint           m_t;
    longint           m_next [NCH];
    logic [DIV_W-1:0] m_shd  [NCH];
    logic [NCH-1:0]   m_tick_v;
    logic [NCH-1:0]   m_sq_v;
    logic [NCH-1:0]   m_lastmode;
    logic [CNT_W-1:0] m_clk;
    logic [3:0]       m_sm;

    function automatic void model_reset();
        m_clk      = '0;
        m_tick_v   = '0;
        m_sq_v     = '0;
        m_lastmode = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            m_shd[ch]  = 16'd99;
            m_next[ch] = m_t + 1 + 99;
        end
    endfunction

    function automatic void model_edge();
        m_t++;
        m_clk++;
        m_sm++;
        for (int ch = 0; ch < NCH; ch++) begin
            logic [DIV_W-1:0] r;
            logic [DIV_W-1:0] nxt;
            logic             base;
            r    = bus.div_ratio[ch*DIV_W +: DIV_W];
            nxt  = bus.div_load[ch] ? r : m_shd[ch];
            base = m_lastmode[ch] ? 1'b0 : m_sq_v[ch];
            if (bus.sync_restart || !bus.ch_en[ch]) begin
                m_tick_v[ch] = 1'b0;
                m_sq_v[ch]   = 1'b0;
                m_next[ch]   = m_t + 1 + longint'(nxt);
            end else if (m_t == m_next[ch]) begin
                m_tick_v[ch] = 1'b1;
                m_sq_v[ch]   = bus.mode[ch] ? 1'b1 : ~base;
                m_next[ch]   = m_t + 1 + longint'(nxt);
            end else begin
                m_tick_v[ch] = 1'b0;
                m_sq_v[ch]   = bus.mode[ch] ? 1'b0 : base;
            end
            if (bus.div_load[ch]) m_shd[ch] = r;
            m_lastmode[ch] = bus.mode[ch];
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        bus.div_load     = '0;
        bus.sync_restart = 1'b0;
    endtask

    task automatic set_ratio(input int ch, input logic [DIV_W-1:0] r);
        bus.div_ratio[ch*DIV_W +: DIV_W] = r;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.clkdiv !== '0 || bus.tick !== '0 || bus.sq !== '0) begin
            errors++;
            $display("FAIL reset_hold clkdiv=%0d tick=%b sq=%b required 0/0/0", bus.clkdiv, bus.tick, bus.sq);
        end
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        model_reset();
        m_sm = '0;
        checks++;
        if (bus.clkdiv !== 32'd0) begin
            errors++;
            $display("FAIL reset_release clkdiv=%0d required 0", bus.clkdiv);
        end
        for (int k = 1; k <= 70; k++) begin
            step();
            checks++;
            if (bus.clkdiv !== m_clk || bus.clkdiv !== CNT_W'(k) || bus.tick !== '0 || bus.sq !== '0) begin
                errors++;
                $display("FAIL reset_count k=%0d clkdiv=%0d/%0d tick=%b sq=%b required 0", k, bus.clkdiv, k, bus.tick, bus.sq);
            end
        end
    endtask

    task automatic test_clkdiv_wrap();
        int wraps = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_sm == 4'd0) wraps++;
            checks++;
            if (sbus.clkdiv !== m_sm || sbus.tick !== 1'b0) begin
                errors++;
                $display("FAIL clkdiv_wrap k=%0d clkdiv=%0d required %0d tick=%b", k, sbus.clkdiv, m_sm, sbus.tick);
            end
        end
        checks++;
        if (wraps == 0) begin
            errors++;
            $display("FAIL clkdiv_wrap_seen wraps=%0d required >0", wraps);
        end
    endtask

    task automatic test_basic();
        bus.ch_en = '0;
        bus.mode  = 4'b0010;
        set_ratio(0, 16'd3);
        set_ratio(1, 16'd0);
        bus.div_load = 4'b0011;
        step();
        bus.ch_en = 4'b0011;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (bus.tick !== m_tick_v || bus.sq !== m_sq_v || bus.clkdiv !== m_clk) begin
                errors++;
                $display("FAIL basic_model k=%0d tick=%b/%b sq=%b/%b", k, bus.tick, m_tick_v, bus.sq, m_sq_v);
            end
            checks++;
            if (bus.tick[0] !== (k % 4 == 0) || bus.sq[0] !== ((k / 4) % 2 == 1) ||
                bus.tick[1] !== 1'b1 || bus.sq[1] !== 1'b1) begin
                errors++;
                $display("FAIL basic_edges k=%0d tick=%b sq=%b", k, bus.tick[1:0], bus.sq[1:0]);
            end
        end
    endtask

    task automatic test_reload();
        for (int ph = 0; ph < 2; ph++) begin
            bus.ch_en = '0;
            bus.mode  = '0;
            set_ratio(0, 16'd9);
            bus.div_load = 4'b0001;
            step();
            bus.ch_en = 4'b0001;
            for (int k = 1; k <= 26; k++) begin
                if (k == (ph == 0 ? 6 : 10)) begin
                    set_ratio(0, 16'd4);
                    bus.div_load = 4'b0001;
                end
                step();
                checks++;
                if (bus.tick !== m_tick_v || bus.sq !== m_sq_v) begin
                    errors++;
                    $display("FAIL reload_model ph=%0d k=%0d tick=%b/%b sq=%b/%b", ph, k, bus.tick, m_tick_v, bus.sq, m_sq_v);
                end
                checks++;
                if (bus.tick[0] !== (k == 10 || (k > 10 && (k - 10) % 5 == 0))) begin
                    errors++;
                    $display("FAIL reload_edges ph=%0d k=%0d tick0=%b", ph, k, bus.tick[0]);
                end
            end
        end
    endtask

    task automatic test_restart();
        bus.ch_en = '0;
        bus.mode  = '0;
        set_ratio(0, 16'd2);
        set_ratio(1, 16'd5);
        bus.div_load = 4'b0011;
        step();
        bus.ch_en = 4'b0011;
        repeat ($urandom_range(3, 12)) step();
        bus.sync_restart = 1'b1;
        step();
        checks++;
        if (bus.tick !== '0 || bus.sq !== '0) begin
            errors++;
            $display("FAIL restart_clear tick=%b sq=%b required 0", bus.tick, bus.sq);
        end
        for (int k = 1; k <= 18; k++) begin
            step();
            checks++;
            if (bus.tick !== m_tick_v || bus.sq !== m_sq_v) begin
                errors++;
                $display("FAIL restart_model k=%0d tick=%b/%b sq=%b/%b", k, bus.tick, m_tick_v, bus.sq, m_sq_v);
            end
            checks++;
            if (bus.tick[0] !== (k % 3 == 0) || bus.tick[1] !== (k % 6 == 0)) begin
                errors++;
                $display("FAIL restart_align k=%0d tick=%b", k, bus.tick[1:0]);
            end
        end
    endtask

    task automatic test_enable_toggle();
        repeat (7) step();
        bus.ch_en[0] = 1'b0;
        set_ratio(0, 16'd4);
        bus.div_load = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.tick[0] !== 1'b0 || bus.sq[0] !== 1'b0 || bus.tick !== m_tick_v) begin
                errors++;
                $display("FAIL disabled_out k=%0d tick=%b sq=%b required ch0 low", k, bus.tick, bus.sq);
            end
        end
        bus.ch_en[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (bus.tick !== m_tick_v || bus.sq !== m_sq_v || bus.tick[0] !== (k % 5 == 0)) begin
                errors++;
                $display("FAIL reenable k=%0d tick=%b/%b sq=%b/%b", k, bus.tick, m_tick_v, bus.sq, m_sq_v);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_ratio(ch, DIV_W'($urandom_range(0, 12)));
                    bus.div_load[ch] = 1'b1;
                end
                if ($urandom_range(0, 39) == 0) bus.ch_en[ch] = ~bus.ch_en[ch];
                if ($urandom_range(0, 49) == 0) bus.mode[ch] = ~bus.mode[ch];
            end
            if ($urandom_range(0, 59) == 0) bus.sync_restart = 1'b1;
            step();
            checks++;
            if (bus.tick !== m_tick_v || bus.sq !== m_sq_v || bus.clkdiv !== m_clk) begin
                errors++;
                $display("FAIL random k=%0d tick=%b/%b sq=%b/%b clkdiv=%0d/%0d", k, bus.tick, m_tick_v, bus.sq, m_sq_v, bus.clkdiv, m_clk);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.ch_en = '0;
        bus.mode  = '0;
        set_ratio(0, 16'd3);
        bus.div_load = 4'b0001;
        step();
        bus.ch_en = 4'b0001;
        repeat (6) step();
        checks++;
        if (bus.sq[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset sq0=%b required 1", bus.sq[0]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.clkdiv !== '0 || bus.tick !== '0 || bus.sq !== '0) begin
            errors++;
            $display("FAIL async_reset clkdiv=%0d tick=%b sq=%b required 0/0/0", bus.clkdiv, bus.tick, bus.sq);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 102; k++) begin
            step();
            checks++;
            if (bus.tick !== m_tick_v || bus.sq !== m_sq_v || bus.clkdiv !== m_clk || bus.tick[0] !== (k == 100)) begin
                errors++;
                $display("FAIL post_reset k=%0d tick=%b/%b sq=%b/%b clkdiv=%0d/%0d", k, bus.tick, m_tick_v, bus.sq, m_sq_v, bus.clkdiv, m_clk);
            end
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        m_t               = 0;
        m_sm              = '0;
        rst_n             = 1'b0;
        rst_s_n           = 1'b0;
        bus.div_ratio     = '0;
        bus.div_load      = '0;
        bus.ch_en         = '0;
        bus.mode          = '0;
        bus.sync_restart  = 1'b0;
        sbus.div_ratio    = '0;
        sbus.div_load     = '0;
        sbus.ch_en        = '0;
        sbus.mode         = '0;
        sbus.sync_restart = 1'b0;
        test_reset();
        test_clkdiv_wrap();
        test_basic();
        test_reload();
        test_restart();
        test_enable_toggle();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
